// File: rtl/samsung_bnn_pkg.sv
// Shared types and arithmetic for the in-NAND BNN sense path: FSM states,
// zero-input detection and the saturating corrected dot product.
package samsung_bnn_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_VECTOR_SIZE = 64;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, CALC, OUT} state_t;

    typedef struct packed {
        logic        sat;
        logic [31:0] dot;
    } dot_res_t;

    function automatic logic is_zero(input logic wl1, input logic wl2);
        return ~wl1 & ~wl2;
    endfunction

    // P = 2*cnt - (S - z), clamped to the signed cnt_w range; the low cnt_w bits of dot are the result.
    function automatic dot_res_t sat_dot(input logic [31:0] cnt, input logic [31:0] s,
                                         input logic [31:0] z, input int cnt_w);
        longint   p, hi, lo;
        dot_res_t r;
        p  = 2 * longint'(cnt) - (longint'(s) - longint'(z));
        hi = (longint'(1) <<< (cnt_w - 1)) - 1;
        lo = -hi - 1;
        r.sat = 1'b0;
        if (p > hi) begin
            p     = hi;
            r.sat = 1'b1;
        end else if (p < lo) begin
            p     = lo;
            r.sat = 1'b1;
        end
        r.dot = p[31:0];
        return r;
    endfunction

endpackage

// File: rtl/samsung_zid_ch_acc.sv
// One bit-line channel: saturating conduction counter plus the result
// registers for the corrected dot product, loaded in CALC.
module samsung_zid_ch_acc
    import samsung_bnn_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             calc,
    input  logic [IDX_W-1:0] s_len,
    input  logic [CNT_W-1:0] z_count,
    output logic [CNT_W-1:0] res_cnt,
    output logic [CNT_W-1:0] res_dot,
    output logic             res_sat
);
    logic [CNT_W-1:0] cnt;
    dot_res_t         d;
    logic             unused_hi;

    assign d         = sat_dot(32'(cnt), 32'(s_len), 32'(z_count), CNT_W);
    assign unused_hi = ^d.dot[31:CNT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            res_cnt <= '0;
            res_dot <= '0;
            res_sat <= 1'b0;
        end else begin
            if (clr)
                cnt <= '0;
            else if (inc && cnt != '1)
                cnt <= cnt + 1'b1;
            if (calc) begin
                res_cnt <= cnt;
                res_dot <= d.dot[CNT_W-1:0];
                res_sat <= d.sat;
            end
        end
    end
endmodule

// File: rtl/samsung_zid_sense_sequencer.sv
// ZID-aware sense sequencer: walks the synapses, issues sense requests and
// produces saturated dot products. Define ZID_SKIP_EN to skip zero-input synapses.
module samsung_zid_sense_sequencer
    import samsung_bnn_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int VECTOR_SIZE = DEF_VECTOR_SIZE,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int IDX_W       = $clog2(VECTOR_SIZE + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          zid_enable,
    input  logic [IDX_W-1:0]              vector_size,
    input  logic [VECTOR_SIZE-1:0]        wl1_is_vpass,
    input  logic [VECTOR_SIZE-1:0]        wl2_is_vpass,
    output logic                          busy,
    output logic                          sense_req_valid,
    input  logic                          sense_req_ready,
    output logic [$clog2(VECTOR_SIZE)-1:0] sense_req_idx,
    input  logic                          sa_valid,
    input  logic [NUM_CH-1:0]             sa_out,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [NUM_CH*CNT_W-1:0]       res_cnt,
    output logic [CNT_W-1:0]              res_zcount,
    output logic [NUM_CH*CNT_W-1:0]       res_dot,
    output logic [NUM_CH-1:0]             res_sat
);
    localparam int RIDX_W = $clog2(VECTOR_SIZE);
    localparam logic [IDX_W-1:0] VS_MAX = IDX_W'(VECTOR_SIZE);
`ifdef ZID_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    state_t                 state;
    logic [VECTOR_SIZE-1:0] wl1, wl2;
    logic [IDX_W-1:0]       s_len, idx;
    logic                   zen;
    logic [CNT_W-1:0]       z_count, z_next;
    logic [RIDX_W-1:0]      idx_lo;
    logic                   cur_zero, skip, mask, clr, inc_en, calc;

    assign idx_lo   = idx[RIDX_W-1:0];
    assign cur_zero = is_zero(wl1[idx_lo], wl2[idx_lo]);
    // Zero synapses are either skipped in SCAN or sensed with their result masked in WAIT.
    assign skip     = SKIP && zen && cur_zero;
    assign mask     = !SKIP && zen && cur_zero;
    assign z_next   = (z_count == '1) ? z_count : z_count + 1'b1;
    assign clr      = (state == IDLE) && start;
    assign inc_en   = (state == WAIT) && sa_valid && !mask;
    assign calc     = (state == CALC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            sense_req_valid <= 1'b0;
            sense_req_idx   <= '0;
            res_valid       <= 1'b0;
            res_zcount      <= '0;
            wl1             <= '0;
            wl2             <= '0;
            s_len           <= '0;
            zen             <= 1'b0;
            idx             <= '0;
            z_count         <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    wl1     <= wl1_is_vpass;
                    wl2     <= wl2_is_vpass;
                    s_len   <= (vector_size > VS_MAX) ? VS_MAX : vector_size;
                    zen     <= zid_enable;
                    idx     <= '0;
                    z_count <= '0;
                    busy    <= 1'b1;
                    state   <= SCAN;
                end
                SCAN: begin
                    if (idx == s_len) begin
                        state <= CALC;
                    end else if (skip) begin
                        idx     <= idx + 1'b1;
                        z_count <= z_next;
                    end else begin
                        sense_req_valid <= 1'b1;
                        sense_req_idx   <= idx_lo;
                        state           <= REQ;
                    end
                end
                REQ: if (sense_req_ready) begin
                    sense_req_valid <= 1'b0;
                    state           <= WAIT;
                end
                WAIT: if (sa_valid) begin
                    if (mask) z_count <= z_next;
                    idx   <= idx + 1'b1;
                    state <= SCAN;
                end
                CALC: begin
                    res_zcount <= z_count;
                    res_valid  <= 1'b1;
                    state      <= OUT;
                end
                OUT: if (res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        samsung_zid_ch_acc #(.CNT_W(CNT_W), .IDX_W(IDX_W)) u_acc (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .inc     (inc_en & sa_out[c]),
            .calc    (calc),
            .s_len   (s_len),
            .z_count (z_count),
            .res_cnt (res_cnt[c*CNT_W +: CNT_W]),
            .res_dot (res_dot[c*CNT_W +: CNT_W]),
            .res_sat (res_sat[c])
        );
    end
endmodule

// File: tb/tb_samsung_zid_sense_sequencer.sv
// Randomized bench for samsung_zid_sense_sequencer (CNT_W=16 and CNT_W=6 instances)
// checked against a list-and-arithmetic reference model.
module tb_samsung_zid_sense_sequencer;
`ifdef ZID_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk, rst, start, zid_enable, sense_req_ready, sa_valid, res_ready;
    logic [6:0]  vector_size;
    logic [63:0] wl1, wl2;
    logic [3:0]  sa_out;
    logic        busy0, srv0, rv0, busy1, srv1, rv1;
    logic [5:0]  sri0, sri1;
    logic [63:0] rc0, rd0;
    logic [15:0] rz0;
    logic [3:0]  rs0, rs1;
    logic [23:0] rc1, rd1;
    logic [5:0]  rz1;

    samsung_zid_sense_sequencer dut0 (
        .clk(clk), .rst(rst), .start(start), .zid_enable(zid_enable), .vector_size(vector_size),
        .wl1_is_vpass(wl1), .wl2_is_vpass(wl2), .busy(busy0), .sense_req_valid(srv0),
        .sense_req_ready(sense_req_ready), .sense_req_idx(sri0), .sa_valid(sa_valid), .sa_out(sa_out),
        .res_valid(rv0), .res_ready(res_ready), .res_cnt(rc0), .res_zcount(rz0), .res_dot(rd0),
        .res_sat(rs0));

    samsung_zid_sense_sequencer #(.CNT_W(6)) dut1 (
        .clk(clk), .rst(rst), .start(start), .zid_enable(zid_enable), .vector_size(vector_size),
        .wl1_is_vpass(wl1), .wl2_is_vpass(wl2), .busy(busy1), .sense_req_valid(srv1),
        .sense_req_ready(sense_req_ready), .sense_req_idx(sri1), .sa_valid(sa_valid), .sa_out(sa_out),
        .res_valid(rv1), .res_ready(res_ready), .res_cnt(rc1), .res_zcount(rz1), .res_dot(rd1),
        .res_sat(rs1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // responder controls (written by the test process only)
    logic [3:0] pat[64];
    int mode = 0, hold = 0;
    bit spur = 0, no_sa = 0;

    // observer state (written by the observer only)
    int reqlog[$];
    bit pending = 0, idx_err = 0, pv = 0;
    int pend_idx = 0, pidx = 0;
    int stall_n = 0;

    // expected values (written by the test process only)
    logic [147:0] exp0;
    logic [57:0]  exp1;
    int expq[$];
    int exp_lat, q0;

    always @(posedge clk) begin
        if (rst) begin
            pending = 0;
            pv = 0;
        end else begin
            if (pv && (!srv0 || int'(sri0) != pidx)) idx_err = 1;
            pv   = srv0 && !sense_req_ready;
            pidx = int'(sri0);
            if (pending && sa_valid) pending = 0;
            if (srv0 && sense_req_ready) begin
                pending  = 1;
                pend_idx = int'(sri0);
                reqlog.push_back(int'(sri0));
            end
        end
    end

    always @(negedge clk) begin
        sense_req_ready = 1'b0;
        sa_valid = 1'b0;
        sa_out = 4'($urandom);
        if (srv0) begin
            if (stall_n < hold) begin
                stall_n++;
                if (spur) begin sa_valid = 1'b1; sa_out = 4'hF; end
            end else if (mode == 0 || $urandom_range(0, 2) == 0) sense_req_ready = 1'b1;
            else sa_valid = 1'($urandom);
        end else if (pending && !no_sa) begin
            if (mode == 0 || $urandom_range(0, 1) == 0) begin
                sa_valid = 1'b1;
                sa_out = pat[pend_idx];
            end
        end else if (mode != 0) sa_valid = 1'($urandom);
        if (hold == 0) stall_n = 0;
    end

    function automatic int sat_cnt(input int v, input int cw);
        int m;
        m = (1 << cw) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic int clampi(input int p, input int cw);
        int hi, lo;
        hi = (1 << (cw - 1)) - 1;
        lo = -(1 << (cw - 1));
        return (p > hi) ? hi : (p < lo) ? lo : p;
    endfunction

    function automatic int req_sig(input int q[$], input int from);
        int h = 0;
        for (int i = from; i < q.size(); i++) h = h * 131 + q[i] + 1;
        return h ^ ((q.size() - from) << 24);
    endfunction

    task automatic predict(input int vs, input bit zen, input logic [63:0] w1, input logic [63:0] w2);
        int s, z;
        int cnt[4];
        logic [63:0] c0v, d0v;
        logic [23:0] c1v, d1v;
        logic [3:0]  s0v, s1v;
        s = (vs > 64) ? 64 : vs;
        z = 0;
        cnt = '{default: 0};
        expq.delete();
        for (int i = 0; i < s; i++) begin
            bit zero;
            zero = !w1[i] && !w2[i];
            if (zen && zero) z++;
            else for (int c = 0; c < 4; c++) cnt[c] += int'(pat[i][c]);
            if (!(SKIP && zen && zero)) expq.push_back(i);
        end
        exp_lat = s + 2 * expq.size() + 3;
        for (int c = 0; c < 4; c++) begin
            int p0, p1;
            p0 = 2 * sat_cnt(cnt[c], 16) - (s - sat_cnt(z, 16));
            p1 = 2 * sat_cnt(cnt[c], 6) - (s - sat_cnt(z, 6));
            c0v[c*16 +: 16] = 16'(sat_cnt(cnt[c], 16));
            d0v[c*16 +: 16] = 16'(clampi(p0, 16));
            s0v[c] = (p0 != clampi(p0, 16));
            c1v[c*6 +: 6] = 6'(sat_cnt(cnt[c], 6));
            d1v[c*6 +: 6] = 6'(clampi(p1, 6));
            s1v[c] = (p1 != clampi(p1, 6));
        end
        exp0 = {c0v, 16'(sat_cnt(z, 16)), d0v, s0v};
        exp1 = {c1v, 6'(sat_cnt(z, 6)), d1v, s1v};
    endtask

    task automatic run_inf(input int vs, input bit zen, input logic [63:0] w1, input logic [63:0] w2,
                           output int lat);
        predict(vs, zen, w1, w2);
        q0 = reqlog.size();
        @(negedge clk);
        vector_size = 7'(vs); zid_enable = zen; wl1 = w1; wl2 = w2; start = 1'b1;
        @(posedge clk); #1;
        // scramble inputs after the snapshot
        start = 1'b0; zid_enable = ~zen; wl1 = {$urandom, $urandom}; wl2 = ~w2; vector_size = 7'($urandom);
        lat = 0;
        while (rv0 !== 1'b1 && lat < 4000) begin @(negedge clk); lat++; end
        if (rv0 !== 1'b1) lat = -1;
    endtask

    task automatic ack_out();
        @(negedge clk); res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); start = 1'b1; vector_size = 7'd3;
        repeat (3) @(negedge clk);
        n_chk++; if ({busy0, srv0, sri0, rv0, rc0, rz0, rd0, rs0} !== '0) begin
            n_fail++; $display("FAIL reset dut0: got %h want 0", {busy0, srv0, sri0, rv0, rc0, rz0, rd0, rs0}); end
        n_chk++; if ({busy1, srv1, sri1, rv1, rc1, rz1, rd1, rs1} !== '0) begin
            n_fail++; $display("FAIL reset dut1: got %h want 0", {busy1, srv1, sri1, rv1, rc1, rz1, rd1, rs1}); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_chk++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset idle busy: got %b want 0", busy0); end
    endtask

    task automatic test_no_zeros();
        int lat;
        mode = 0;
        for (int i = 0; i < 64; i++) pat[i] = 4'b0101;
        run_inf(8, 1'b1, 64'h0F, 64'hF0, lat);
        n_chk++; if ({rc0, rz0, rd0, rs0} !== exp0) begin n_fail++; $display("FAIL no_zeros res0: got %h want %h", {rc0, rz0, rd0, rs0}, exp0); end
        n_chk++; if ({rc1, rz1, rd1, rs1} !== exp1) begin n_fail++; $display("FAIL no_zeros res1: got %h want %h", {rc1, rz1, rd1, rs1}, exp1); end
        n_chk++; if (req_sig(reqlog, q0) !== req_sig(expq, 0)) begin n_fail++; $display("FAIL no_zeros reqs: got %0d want %0d", reqlog.size() - q0, expq.size()); end
        n_chk++; if (lat !== exp_lat) begin n_fail++; $display("FAIL no_zeros latency: got %0d want %0d", lat, exp_lat); end
        ack_out();
        repeat (2) @(negedge clk);
        n_chk++; if ({busy0, rv0, rc0, rz0, rd0, rs0} !== {2'b00, exp0}) begin n_fail++; $display("FAIL no_zeros held: got %h want %h", {busy0, rv0, rc0, rz0, rd0, rs0}, {2'b00, exp0}); end
    endtask

    task automatic test_zid();
        int lat;
        mode = 0;
        for (int i = 0; i < 64; i++) pat[i] = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            run_inf(8, (k == 0), 64'h08, 64'h00, lat);
            n_chk++; if ({rc0, rz0, rd0, rs0} !== exp0) begin n_fail++; $display("FAIL zid%0d res0: got %h want %h", k, {rc0, rz0, rd0, rs0}, exp0); end
            n_chk++; if (req_sig(reqlog, q0) !== req_sig(expq, 0)) begin n_fail++; $display("FAIL zid%0d reqs: got %0d want %0d", k, reqlog.size() - q0, expq.size()); end
            n_chk++; if (lat !== exp_lat) begin n_fail++; $display("FAIL zid%0d latency: got %0d want %0d", k, lat, exp_lat); end
            ack_out();
        end
    endtask

    task automatic test_zero_len();
        int lat;
        mode = 0;
        run_inf(0, 1'b1, 64'hFFFF, 64'h0, lat);
        n_chk++; if ({rc0, rz0, rd0, rs0} !== exp0) begin n_fail++; $display("FAIL zero_len res0: got %h want %h", {rc0, rz0, rd0, rs0}, exp0); end
        n_chk++; if (reqlog.size() !== q0) begin n_fail++; $display("FAIL zero_len reqs: got %0d want 0", reqlog.size() - q0); end
        n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL zero_len latency: got %0d want 3", lat); end
        ack_out();
    endtask

    task automatic test_saturation();
        int lat;
        logic [63:0] w1s[3];
        logic [3:0]  ps[3];
        mode = 0;
        w1s = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        ps  = '{4'hF, 4'h0, 4'hF};
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 64; i++) pat[i] = ps[k];
            run_inf(100, 1'b1, w1s[k], 64'h0, lat);
            n_chk++; if ({rc0, rz0, rd0, rs0} !== exp0) begin n_fail++; $display("FAIL sat%0d res0: got %h want %h", k, {rc0, rz0, rd0, rs0}, exp0); end
            n_chk++; if ({rc1, rz1, rd1, rs1} !== exp1) begin n_fail++; $display("FAIL sat%0d res1: got %h want %h", k, {rc1, rz1, rd1, rs1}, exp1); end
            n_chk++; if (req_sig(reqlog, q0) !== req_sig(expq, 0)) begin n_fail++; $display("FAIL sat%0d reqs: got %0d want %0d", k, reqlog.size() - q0, expq.size()); end
            ack_out();
        end
    endtask

    task automatic test_stall();
        int lat;
        mode = 0; hold = 5; spur = 1'b1;
        for (int i = 0; i < 64; i++) pat[i] = 4'h0;
        run_inf(3, 1'b1, 64'h7, 64'h0, lat);
        hold = 0; spur = 1'b0;
        n_chk++; if ({rc0, rz0, rd0, rs0} !== exp0) begin n_fail++; $display("FAIL stall res0: got %h want %h", {rc0, rz0, rd0, rs0}, exp0); end
        n_chk++; if (idx_err !== 1'b0) begin n_fail++; $display("FAIL stall stable: request changed while stalled, got %b want 0", idx_err); end
        n_chk++; if (lat !== exp_lat + 5) begin n_fail++; $display("FAIL stall latency: got %0d want %0d", lat, exp_lat + 5); end
        ack_out();
    endtask

    task automatic test_rst_abort();
        int lat;
        mode = 0; no_sa = 1'b1;
        for (int i = 0; i < 64; i++) pat[i] = 4'($urandom);
        @(negedge clk);
        vector_size = 7'd5; zid_enable = 1'b1; wl1 = '1; wl2 = '0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 50 && !pending; k++) @(negedge clk);
        n_chk++; if (pending !== 1'b1) begin n_fail++; $display("FAIL rst_abort reach_wait: got %b want 1", pending); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; no_sa = 1'b0;
        n_chk++; if ({busy0, srv0, rv0, rc0, rz0, rd0, rs0} !== '0) begin n_fail++; $display("FAIL rst_abort cleared: got %h want 0", {busy0, srv0, rv0, rc0, rz0, rd0, rs0}); end
        run_inf(2, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, lat);
        n_chk++; if ({rc0, rz0, rd0, rs0} !== exp0) begin n_fail++; $display("FAIL rst_abort res0: got %h want %h", {rc0, rz0, rd0, rs0}, exp0); end
        n_chk++; if (req_sig(reqlog, q0) !== req_sig(expq, 0)) begin n_fail++; $display("FAIL rst_abort reqs: got %0d want %0d", reqlog.size() - q0, expq.size()); end
        n_chk++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rst_abort latency: got %0d want %0d", lat, exp_lat); end
        ack_out();
    endtask

    task automatic test_random();
        int lat;
        mode = 1;
        for (int it = 0; it < 20; it++) begin
            logic [63:0] w1, w2;
            w1 = {$urandom, $urandom} & {$urandom, $urandom};
            w2 = {$urandom, $urandom} & {$urandom, $urandom};
            for (int i = 0; i < 64; i++) pat[i] = 4'($urandom);
            run_inf($urandom_range(0, 80), 1'($urandom), w1, w2, lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n_chk++; if (lat < 0) begin n_fail++; $display("FAIL rand%0d timeout: res_valid never rose", it); end
            n_chk++; if ({rc0, rz0, rd0, rs0} !== exp0) begin n_fail++; $display("FAIL rand%0d res0: got %h want %h", it, {rc0, rz0, rd0, rs0}, exp0); end
            n_chk++; if ({rc1, rz1, rd1, rs1} !== exp1) begin n_fail++; $display("FAIL rand%0d res1: got %h want %h", it, {rc1, rz1, rd1, rs1}, exp1); end
            n_chk++; if (req_sig(reqlog, q0) !== req_sig(expq, 0)) begin n_fail++; $display("FAIL rand%0d reqs: got %0d want %0d", it, reqlog.size() - q0, expq.size()); end
            ack_out();
        end
        n_chk++; if (idx_err !== 1'b0) begin n_fail++; $display("FAIL rand stable: request changed while stalled, got %b want 0", idx_err); end
        mode = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; zid_enable = 1'b0; vector_size = '0; wl1 = '0; wl2 = '0;
        res_ready = 1'b0;
        for (int i = 0; i < 64; i++) pat[i] = '0;
        test_reset();
        test_no_zeros();
        test_zid();
        test_zero_len();
        test_saturation();
        test_stall();
        test_rst_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
